// File: rtl/gpio_irq_ctrl.sv
// Per-pin GPIO interrupt capture with a single-request presenter: pending pins are
// offered to the host one at a time, lowest index first, with a one-cycle gap after each ack.
module gpio_irq_ctrl #(
    parameter int N_PINS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PINS-1:0] irq_pin_change,
    input  logic [N_PINS-1:0] irq_int,
    input  logic [N_PINS-1:0] irq_enable,
    input  logic              ack,
    input  logic              clr_status,
    output logic              irq_req,
    output logic [2:0]        irq_id,
    output logic [1:0]        irq_cause,
    output logic [N_PINS-1:0] pending,
    output logic [N_PINS-1:0] overflow,
    output logic              spurious_ack
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t            state_reg, state_next;
    logic [N_PINS-1:0] pending_reg, pending_next;
    logic [N_PINS-1:0] cause_pc_reg, cause_pc_next;
    logic [N_PINS-1:0] cause_int_reg, cause_int_next;
    logic [N_PINS-1:0] overflow_reg, overflow_next;
    logic              spurious_reg, spurious_next;
    logic [2:0]        id_reg, id_next;
    logic [1:0]        cause_reg, cause_next;

    logic [N_PINS-1:0] ev;
    logic [N_PINS-1:0] ack_hit;
    logic [N_PINS-1:0] eligible;
    logic [2:0]        sel_id;
    logic [1:0]        sel_cause;

    assign ev       = (irq_pin_change | irq_int) & irq_enable;
    assign eligible = pending_reg & irq_enable;

    // An ack clears the presented pin first; a same-cycle event then re-arms it with fresh causes.
    for (genvar gi = 0; gi < N_PINS; gi++) begin : g_pin
        assign ack_hit[gi]        = (state_reg == REQ) && ack && (id_reg == 3'(gi));
        assign pending_next[gi]   = ev[gi] | (pending_reg[gi] & ~ack_hit[gi]);
        assign cause_pc_next[gi]  = (ev[gi] & irq_pin_change[gi]) | (cause_pc_reg[gi] & ~ack_hit[gi]);
        assign cause_int_next[gi] = (ev[gi] & irq_int[gi]) | (cause_int_reg[gi] & ~ack_hit[gi]);
        assign overflow_next[gi]  = (ev[gi] & pending_reg[gi] & ~ack_hit[gi])
                                  | (overflow_reg[gi] & ~clr_status);
    end

    assign spurious_next = (ack && (state_reg != REQ)) | (spurious_reg & ~clr_status);

    // Descending scan so the lowest eligible index is the one left standing.
    always_comb begin
        sel_id    = '0;
        sel_cause = '0;
        for (int i = N_PINS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id    = 3'(i);
                sel_cause = {cause_int_reg[i], cause_pc_reg[i]};
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        cause_next = cause_reg;
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    state_next = REQ;
                    id_next    = sel_id;
                    cause_next = sel_cause;
                end
            end
            REQ: begin
                if (ack) state_next = GAP;
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            cause_pc_reg  <= '0;
            cause_int_reg <= '0;
            overflow_reg  <= '0;
            spurious_reg  <= 1'b0;
            id_reg        <= '0;
            cause_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            cause_pc_reg  <= cause_pc_next;
            cause_int_reg <= cause_int_next;
            overflow_reg  <= overflow_next;
            spurious_reg  <= spurious_next;
            id_reg        <= id_next;
            cause_reg     <= cause_next;
        end
    end

    assign irq_req      = (state_reg == REQ);
    assign irq_id       = id_reg;
    assign irq_cause    = cause_reg;
    assign pending      = pending_reg;
    assign overflow     = overflow_reg;
    assign spurious_ack = spurious_reg;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: a per-pin array model predicts status every cycle and
// the sequence of presented interrupts; directed scenarios followed by random traffic.
module tb_gpio_irq_ctrl;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] pc_in, int_in, en_in;
    logic         ack_in, clr_in;
    logic         irq_req;
    logic [2:0]   irq_id;
    logic [1:0]   irq_cause;
    logic [N-1:0] pending, overflow;
    logic         spurious_ack;

    always #5 clk = ~clk;

    gpio_irq_ctrl #(.N_PINS(N)) dut (
        .clk(clk), .reset(reset),
        .irq_pin_change(pc_in), .irq_int(int_in), .irq_enable(en_in),
        .ack(ack_in), .clr_status(clr_in),
        .irq_req(irq_req), .irq_id(irq_id), .irq_cause(irq_cause),
        .pending(pending), .overflow(overflow), .spurious_ack(spurious_ack)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic         req;
        logic [2:0]   id;
        logic [1:0]   cause;
        logic [N-1:0] pend;
        logic [N-1:0] ovf;
        logic         spur;
    } status_t;

    status_t    exp_q[$];
    logic [4:0] pres_q[$];

    // Reference model: per-pin flags plus a presenter phase (0 idle, 1 presenting, 2 gap).
    bit       m_pend[N], m_pc[N], m_int[N], m_ovf[N];
    bit       m_spur  = 0;
    int       m_phase = 0;
    int       m_id    = 0;
    bit [1:0] m_cause = 0;

    always @(posedge clk) begin : model
        status_t s;
        int      acked;
        bit      ev;
        bit      found;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_pc[i] = 0; m_int[i] = 0; m_ovf[i] = 0;
            end
            m_spur = 0; m_phase = 0; m_id = 0; m_cause = 0;
        end else begin
            acked = (m_phase == 1 && ack_in) ? m_id : -1;
            if (ack_in && m_phase != 1) m_spur = 1;
            else if (clr_in)            m_spur = 0;
            if (m_phase == 0) begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    if (!found && m_pend[i] && en_in[i]) begin
                        found   = 1;
                        m_id    = i;
                        m_cause = {m_int[i], m_pc[i]};
                        m_phase = 1;
                        pres_q.push_back({3'(i), m_int[i], m_pc[i]});
                    end
                end
            end else if (m_phase == 1) begin
                if (ack_in) m_phase = 2;
            end else begin
                m_phase = 0;
            end
            if (clr_in)
                for (int i = 0; i < N; i++) m_ovf[i] = 0;
            for (int i = 0; i < N; i++) begin
                ev = (pc_in[i] | int_in[i]) & en_in[i];
                if (i == acked) begin
                    m_pend[i] = 0; m_pc[i] = 0; m_int[i] = 0;
                end else if (ev && m_pend[i]) begin
                    m_ovf[i] = 1;
                end
                if (ev) begin
                    m_pend[i] = 1;
                    m_pc[i]   = m_pc[i] | pc_in[i];
                    m_int[i]  = m_int[i] | int_in[i];
                end
            end
        end
        s       = '0;
        s.req   = (m_phase == 1);
        s.id    = 3'(m_id);
        s.cause = m_cause;
        s.spur  = m_spur;
        for (int i = 0; i < N; i++) begin
            s.pend[i] = m_pend[i];
            s.ovf[i]  = m_ovf[i];
        end
        exp_q.push_back(s);
    end

    // Monitor: per-cycle status compare, plus one presentation check on each rise of irq_req.
    logic prev_req = 1'b0;
    always @(negedge clk) begin : monitor
        status_t    e;
        status_t    a;
        logic [4:0] p;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {irq_req, irq_id, irq_cause, pending, overflow, spurious_ack};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL status @%0t: got req=%b id=%0d cause=%b pend=%h ovf=%h spur=%b, required req=%b id=%0d cause=%b pend=%h ovf=%h spur=%b",
                         $time, a.req, a.id, a.cause, a.pend, a.ovf, a.spur,
                         e.req, e.id, e.cause, e.pend, e.ovf, e.spur);
            end
        end
        if (irq_req === 1'b1 && prev_req !== 1'b1) begin
            tests++;
            if (pres_q.size() == 0) begin
                fails++;
                $display("FAIL present @%0t: got id=%0d cause=%b, required no request", $time, irq_id, irq_cause);
            end else begin
                p = pres_q.pop_front();
                if ({irq_id, irq_cause} !== p) begin
                    fails++;
                    $display("FAIL present @%0t: got id=%0d cause=%b, required id=%0d cause=%b",
                             $time, irq_id, irq_cause, p[4:2], p[1:0]);
                end
            end
        end
        prev_req <= irq_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] pc, input logic [N-1:0] it,
                         input logic a, input logic c, input logic r);
        pc_in = pc; int_in = it; ack_in = a; clr_in = c; reset = r;
        @(negedge clk);
    endtask

    task automatic wait_req(input int limit);
        int n = 0;
        while (irq_req !== 1'b1 && n < limit) begin
            drive('0, '0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        tests++;
        if (irq_req !== 1'b1) begin
            fails++;
            $display("FAIL wait_req: irq_req=%b after %0d cycles, required 1", irq_req, limit);
        end
    endtask

    function automatic logic [N-1:0] sparse();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 5) == 0);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        pc_in = '0; int_in = '0; en_in = 8'hFF; ack_in = 0; clr_in = 0; reset = 1;
        @(negedge clk);
        drive('0, '0, 0, 0, 1);
        chk("rst_req", irq_req, 0);
        chk("rst_id", irq_id, 0);
        chk("rst_cause", irq_cause, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_spur", spurious_ack, 0);

        // Single int pulse on pin 3
        drive('0, 8'h08, 0, 0, 0);
        chk("p3_pend", pending, 8'h08);
        chk("p3_req_early", irq_req, 0);
        drive('0, '0, 0, 0, 0);
        chk("p3_req", irq_req, 1);
        chk("p3_id", irq_id, 3);
        chk("p3_cause", irq_cause, 2'b10);
        drive('0, '0, 1, 0, 0);
        chk("p3_ack_pend", pending, 0);
        chk("p3_gap", irq_req, 0);
        drive('0, '0, 0, 0, 0);
        chk("p3_idle", irq_req, 0);
        drive('0, '0, 0, 0, 0);
        chk("p3_stay", irq_req, 0);

        // Pin 5 pin-change and pin 1 int together: ascending service
        drive(8'h20, 8'h02, 0, 0, 0);
        chk("two_pend", pending, 8'h22);
        drive('0, '0, 0, 0, 0);
        chk("two_id1", irq_id, 1);
        chk("two_cause1", irq_cause, 2'b10);
        drive('0, '0, 1, 0, 0);
        chk("two_gap", irq_req, 0);
        wait_req(4);
        chk("two_id5", irq_id, 5);
        chk("two_cause5", irq_cause, 2'b01);
        drive('0, '0, 1, 0, 0);
        drive('0, '0, 0, 0, 0);

        // Overflow on pin 2, then clr_status
        drive(8'h04, '0, 0, 0, 0);
        drive(8'h04, '0, 0, 0, 0);
        chk("ovf_set", overflow, 8'h04);
        drive('0, '0, 0, 1, 0);
        chk("ovf_clr", overflow, 0);
        chk("ovf_pend_kept", pending, 8'h04);
        drive('0, '0, 1, 0, 0);
        drive('0, '0, 0, 0, 0);
        drive('0, '0, 0, 0, 0);

        // Ack and new event on the acked pin in the same cycle
        drive('0, 8'h04, 0, 0, 0);
        wait_req(4);
        chk("reack_id", irq_id, 2);
        drive('0, 8'h04, 1, 0, 0);
        chk("reack_pend", pending, 8'h04);
        chk("reack_ovf", overflow, 0);
        wait_req(4);
        chk("reack_id2", irq_id, 2);
        chk("reack_cause", irq_cause, 2'b10);
        drive('0, '0, 1, 0, 0);
        drive('0, '0, 0, 0, 0);
        drive('0, '0, 0, 0, 0);

        // All disabled, then ack in IDLE
        en_in = '0;
        drive(8'hFF, 8'hFF, 0, 0, 0);
        chk("dis_pend", pending, 0);
        chk("dis_req", irq_req, 0);
        drive('0, '0, 1, 0, 0);
        chk("spur_set", spurious_ack, 1);
        drive('0, '0, 0, 1, 0);
        chk("spur_clr", spurious_ack, 0);
        en_in = 8'hFF;

        // Reset while presenting
        drive(8'h81, '0, 0, 0, 0);
        chk("rstreq_pend", pending, 8'h81);
        drive('0, '0, 0, 0, 0);
        chk("rstreq_req", irq_req, 1);
        drive('0, '0, 0, 0, 1);
        chk("rstreq_req0", irq_req, 0);
        chk("rstreq_pend0", pending, 0);
        chk("rstreq_id0", irq_id, 0);
        drive('0, '0, 0, 0, 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) en_in = N'($urandom);
            drive(sparse(), sparse(),
                  irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0),
                  $urandom_range(0, 40) == 0,
                  $urandom_range(0, 300) == 0);
        end

        en_in = 8'hFF;
        for (int c = 0; c < 6; c++) drive('0, '0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pres_drained", pres_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
